// File: rtl/alu_issue_if.sv
// Handshake bundle between the decode stage, alu_issue and the ALU/execute stage.
// The slave modport is the alu_issue side. The master modport is the upstream/downstream environment side.
interface alu_issue_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;

    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [3:0]  alu_op;
    logic [4:0]  rd;
    logic        rd_we;
    logic        is_branch;
    logic [2:0]  br_funct3;
    logic        illegal;

    modport slave (
        input  in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        output in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we,
               is_branch, br_funct3, illegal
    );

    modport master (
        output in_valid, instr, pc, rs1_data, rs2_data, out_ready,
        input  in_ready, out_valid, alu_a, alu_b, alu_op, rd, rd_we,
               is_branch, br_funct3, illegal
    );
endinterface

// File: rtl/alu_issue.sv
// RV32I decode-and-issue stage: operand/op selection feeding a two-slot skid buffer.
// Optional macro ALU_ISSUE_SHAMT_MASK_EN masks shift amounts to 5 bits.
module alu_issue (
    input  logic       clk,
    input  logic       n_rst,
    alu_issue_if.slave bus
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

`ifdef ALU_ISSUE_SHAMT_MASK_EN
    localparam bit SHAMT_MASK = 1'b1;
`else
    localparam bit SHAMT_MASK = 1'b0;
`endif

    typedef enum logic [3:0] {
        ALU_ADD  = 4'b0000,
        ALU_SLL  = 4'b0001,
        ALU_SLT  = 4'b0010,
        ALU_SLTU = 4'b0011,
        ALU_XOR  = 4'b0100,
        ALU_SRL  = 4'b0101,
        ALU_OR   = 4'b0110,
        ALU_AND  = 4'b0111,
        ALU_SUB  = 4'b1000,
        ALU_SRA  = 4'b1101
    } alu_op_e;

    typedef struct packed {
        logic [31:0] alu_a;
        logic [31:0] alu_b;
        alu_op_e     alu_op;
        logic [4:0]  rd;
        logic        rd_we;
        logic        is_branch;
        logic [2:0]  br_funct3;
        logic        illegal;
    } issue_t;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_u;
    logic [31:0] shamt;
    logic        bad;
    issue_t      dec;

    assign opcode = bus.instr[6:0];
    assign funct3 = bus.instr[14:12];
    assign funct7 = bus.instr[31:25];
    assign imm_i  = {{20{bus.instr[31]}}, bus.instr[31:20]};
    assign imm_s  = {{20{bus.instr[31]}}, bus.instr[31:25], bus.instr[11:7]};
    assign imm_u  = {bus.instr[31:12], 12'b0};
    assign shamt  = {27'b0, bus.instr[24:20]};

    // NOTE: every signal written here gets a default first, so no path leaves a latch.
    always_comb begin
        dec     = '0;
        bad     = 1'b0;
        dec.rd  = bus.instr[11:7];
        case (opcode)
            OPC_OP: begin
                dec.alu_a = bus.rs1_data;
                dec.alu_b = bus.rs2_data;
                dec.rd_we = 1'b1;
                dec.alu_op = alu_op_e'({1'b0, funct3});
                if (funct7 == F7_ALT) begin
                    if (funct3 == 3'b000)      dec.alu_op = ALU_SUB;
                    else if (funct3 == 3'b101) dec.alu_op = ALU_SRA;
                    else                       bad = 1'b1;
                end else if (funct7 != F7_BASE) begin
                    bad = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                dec.alu_a  = bus.rs1_data;
                dec.alu_b  = imm_i;
                dec.rd_we  = 1'b1;
                dec.alu_op = alu_op_e'({1'b0, funct3});
                // Shift immediates carry funct7 in imm[11:5]; only the shamt field is an operand.
                if (funct3 == 3'b001 || funct3 == 3'b101) begin
                    dec.alu_b = shamt;
                    if (funct3 == 3'b101 && funct7 == F7_ALT) dec.alu_op = ALU_SRA;
                    else if (funct7 != F7_BASE)               bad = 1'b1;
                end
            end
            OPC_LUI: begin
                dec.alu_b = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_AUIPC: begin
                dec.alu_a = bus.pc;
                dec.alu_b = imm_u;
                dec.rd_we = 1'b1;
            end
            OPC_JAL, OPC_JALR: begin
                dec.alu_a = bus.pc;
                dec.alu_b = 32'd4;
                dec.rd_we = 1'b1;
            end
            OPC_LOAD: begin
                dec.alu_a = bus.rs1_data;
                dec.alu_b = imm_i;
                dec.rd_we = 1'b1;
            end
            OPC_STORE: begin
                dec.alu_a = bus.rs1_data;
                dec.alu_b = imm_s;
            end
            OPC_BRANCH: begin
                dec.alu_a     = bus.rs1_data;
                dec.alu_b     = bus.rs2_data;
                dec.alu_op    = ALU_SUB;
                dec.is_branch = 1'b1;
                dec.br_funct3 = funct3;
                if (funct3 == 3'b010 || funct3 == 3'b011) bad = 1'b1;
            end
            default: bad = 1'b1;
        endcase

        if (SHAMT_MASK && (dec.alu_op == ALU_SLL || dec.alu_op == ALU_SRL ||
                           dec.alu_op == ALU_SRA)) begin
            dec.alu_b = {27'b0, dec.alu_b[4:0]};
        end

        if (bad) begin
            dec         = '0;
            dec.rd      = bus.instr[11:7];
            dec.illegal = 1'b1;
        end

        if (dec.rd == 5'd0) dec.rd_we = 1'b0;
    end

    issue_t main_q, main_d;
    issue_t skid_q, skid_d;
    logic   main_valid_q, main_valid_d;
    logic   skid_valid_q, skid_valid_d;
    logic   accept;

    assign bus.in_ready = n_rst & ~skid_valid_q;
    assign accept       = bus.in_valid & bus.in_ready;

    always_comb begin
        main_d       = main_q;
        main_valid_d = main_valid_q;
        skid_d       = skid_q;
        skid_valid_d = skid_valid_q;
        if (skid_valid_q) begin
            // in_ready is low here, so only a drain can change state.
            if (bus.out_ready) begin
                main_d       = skid_q;
                skid_valid_d = 1'b0;
            end
        end else if (accept) begin
            if (!main_valid_q || bus.out_ready) begin
                main_d       = dec;
                main_valid_d = 1'b1;
            end else begin
                skid_d       = dec;
                skid_valid_d = 1'b1;
            end
        end else if (main_valid_q && bus.out_ready) begin
            main_valid_d = 1'b0;
        end
    end

    // NOTE: payload slots are reset too, because the outputs come straight from main_q
    // and must read as zero after reset. Non-blocking assignments keep every flop
    // sampling pre-edge values.
    always_ff @(posedge clk) begin
        if (!n_rst) begin
            main_q       <= '0;
            skid_q       <= '0;
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_q       <= main_d;
            skid_q       <= skid_d;
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    assign bus.out_valid = main_valid_q;
    assign bus.alu_a     = main_q.alu_a;
    assign bus.alu_b     = main_q.alu_b;
    assign bus.alu_op    = main_q.alu_op;
    assign bus.rd        = main_q.rd;
    assign bus.rd_we     = main_q.rd_we;
    assign bus.is_branch = main_q.is_branch;
    assign bus.br_funct3 = main_q.br_funct3;
    assign bus.illegal   = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Self-checking bench for alu_issue: a queue-based flow model plus a spec-level decode model,
// directed literal cases and randomized traffic.
module tb_alu_issue;

    logic clk = 1'b0;
    logic n_rst;
    always #5 clk = ~clk;

    alu_issue_if bus ();

    alu_issue dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        logic [2:0]  f3;
        logic        ill;
    } exp_t;

    // Bundles accepted but not yet consumed, oldest first.
    exp_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] ins, input logic [31:0] pc_v,
                                   input logic [31:0] r1, input logic [31:0] r2);
        exp_t       e;
        logic [6:0] opc = ins[6:0];
        logic [2:0] f3  = ins[14:12];
        logic [6:0] f7  = ins[31:25];
        logic       ok  = 1'b1;
        e = '{default: '0};
        e.rd = ins[11:7];
        case (opc)
            7'h33: begin
                e.a = r1; e.b = r2; e.we = 1'b1;
                if (f7 == 7'h00)                             e.op = {1'b0, f3};
                else if (f7 == 7'h20 && f3 == 3'd0)          e.op = 4'd8;
                else if (f7 == 7'h20 && f3 == 3'd5)          e.op = 4'd13;
                else                                         ok = 1'b0;
            end
            7'h13: begin
                e.a = r1; e.we = 1'b1; e.op = {1'b0, f3};
                e.b = {{20{ins[31]}}, ins[31:20]};
                if (f3 == 3'd1 || f3 == 3'd5) begin
                    e.b = 32'(ins[24:20]);
                    if (f3 == 3'd5 && f7 == 7'h20) e.op = 4'd13;
                    else if (f7 != 7'h00)          ok = 1'b0;
                end
            end
            7'h37: begin e.a = 0;    e.b = {ins[31:12], 12'h000}; e.we = 1'b1; end
            7'h17: begin e.a = pc_v; e.b = {ins[31:12], 12'h000}; e.we = 1'b1; end
            7'h6f, 7'h67: begin e.a = pc_v; e.b = 32'd4; e.we = 1'b1; end
            7'h03: begin e.a = r1; e.b = {{20{ins[31]}}, ins[31:20]}; e.we = 1'b1; end
            7'h23: begin e.a = r1; e.b = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
            7'h63: begin
                e.a = r1; e.b = r2; e.op = 4'd8; e.br = 1'b1; e.f3 = f3;
                if (f3 == 3'd2 || f3 == 3'd3) ok = 1'b0;
            end
            default: ok = 1'b0;
        endcase
`ifdef ALU_ISSUE_SHAMT_MASK_EN
        if (ok && (e.op == 4'd1 || e.op == 4'd5 || e.op == 4'd13)) e.b = e.b % 32;
`endif
        if (!ok) begin
            e = '{default: '0};
            e.rd  = ins[11:7];
            e.ill = 1'b1;
        end
        if (e.rd == 5'd0) e.we = 1'b0;
        return e;
    endfunction

    task automatic compare_outputs();
        check("in_ready",  32'(bus.in_ready),  32'(n_rst && q.size() < 2));
        check("out_valid", 32'(bus.out_valid), 32'(q.size() > 0));
        if (q.size() > 0) begin
            check("alu_a",     bus.alu_a,            q[0].a);
            check("alu_b",     bus.alu_b,            q[0].b);
            check("alu_op",    32'(bus.alu_op),      32'(q[0].op));
            check("rd",        32'(bus.rd),          32'(q[0].rd));
            check("rd_we",     32'(bus.rd_we),       32'(q[0].we));
            check("is_branch", 32'(bus.is_branch),   32'(q[0].br));
            check("br_funct3", 32'(bus.br_funct3),   32'(q[0].f3));
            check("illegal",   32'(bus.illegal),     32'(q[0].ill));
        end
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] p,
                         input logic [31:0] r1, input logic [31:0] r2, input logic ordy);
        bus.in_valid  = v;
        bus.instr     = ins;
        bus.pc        = p;
        bus.rs1_data  = r1;
        bus.rs2_data  = r2;
        bus.out_ready = ordy;
    endtask

    // One clock: note handshakes before the edge, update the model at the edge, compare after it.
    task automatic step();
        logic acc;
        logic drn;
        exp_t e;
        #1;
        acc = bus.in_valid && bus.in_ready;
        drn = bus.out_valid && bus.out_ready;
        e   = model(bus.instr, bus.pc, bus.rs1_data, bus.rs2_data);
        @(posedge clk);
        if (!n_rst) begin
            q.delete();
        end else begin
            if (drn && q.size() > 0) void'(q.pop_front());
            if (acc) q.push_back(e);
        end
        #1;
        compare_outputs();
        @(negedge clk);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] w = $urandom;
        int          k = $urandom_range(0, 11);
        case (k)
            0, 1:    w[6:0] = 7'h33;
            2, 3:    w[6:0] = 7'h13;
            4:       w[6:0] = 7'h37;
            5:       w[6:0] = 7'h17;
            6:       w[6:0] = 7'h6f;
            7:       w[6:0] = 7'h67;
            8:       w[6:0] = 7'h03;
            9:       w[6:0] = 7'h23;
            10:      w[6:0] = 7'h63;
            default: ;
        endcase
        if ($urandom_range(0, 3) != 0) w[31:25] = ($urandom_range(0, 1) != 0) ? 7'h00 : 7'h20;
        return w;
    endfunction

    function automatic logic [31:0] rand_data();
        return ($urandom_range(0, 3) == 0) ? 32'h0000_0021 : $urandom;
    endfunction

    localparam logic [31:0] ADD_X2 = 32'h0020_8133;
    logic [31:0] exp_sll_b;

    initial begin
        n_rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        step();
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_in_ready",  32'(bus.in_ready),  32'd0);
        n_rst = 1'b1;
        step();
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);

        drive(1'b1, ADD_X2, 32'h100, 32'd5, 32'd7, 1'b1);
        step();
        check("add_valid", 32'(bus.out_valid), 32'd1);
        check("add_a",     bus.alu_a,          32'd5);
        check("add_b",     bus.alu_b,          32'd7);
        check("add_op",    32'(bus.alu_op),    32'd0);
        check("add_rd",    32'(bus.rd),        32'd2);
        check("add_we",    32'(bus.rd_we),     32'd1);

        drive(1'b1, 32'h4020_D113, 32'h104, 32'hFFFF_FFF8, 32'd0, 1'b1);
        step();
        check("srai_op", 32'(bus.alu_op), 32'd13);
        check("srai_b",  bus.alu_b,       32'd2);

        drive(1'b1, 32'h4020_9113, 32'h108, 32'd1, 32'd1, 1'b1);
        step();
        check("ill_flag", 32'(bus.illegal), 32'd1);
        check("ill_we",   32'(bus.rd_we),   32'd0);

        drive(1'b1, 32'h0020_8463, 32'h10C, 32'd9, 32'd9, 1'b1);
        step();
        check("beq_op", 32'(bus.alu_op),    32'd8);
        check("beq_br", 32'(bus.is_branch), 32'd1);
        check("beq_f3", 32'(bus.br_funct3), 32'd0);
        check("beq_we", 32'(bus.rd_we),     32'd0);

`ifdef ALU_ISSUE_SHAMT_MASK_EN
        exp_sll_b = 32'h0000_0001;
`else
        exp_sll_b = 32'h0000_0021;
`endif
        drive(1'b1, 32'h0020_91B3, 32'h110, 32'd1, 32'h0000_0021, 1'b1);
        step();
        check("sll_op", 32'(bus.alu_op), 32'd1);
        check("sll_b",  bus.alu_b,       exp_sll_b);

        drive(1'b0, 0, 0, 0, 0, 1'b1);
        step();

        // Back-pressure: three back-to-back bundles against a stalled consumer.
        drive(1'b1, ADD_X2, 0, 32'd11, 0, 1'b0);
        step();
        check("bp1_a",     bus.alu_a,          32'd11);
        check("bp1_ready", 32'(bus.in_ready),  32'd1);
        drive(1'b1, ADD_X2, 0, 32'd22, 0, 1'b0);
        step();
        check("bp2_ready", 32'(bus.in_ready),  32'd0);
        check("bp2_a",     bus.alu_a,          32'd11);
        drive(1'b1, ADD_X2, 0, 32'd33, 0, 1'b0);
        step();
        check("bp3_ready", 32'(bus.in_ready),  32'd0);
        check("bp3_hold",  bus.alu_a,          32'd11);
        drive(1'b1, ADD_X2, 0, 32'd33, 0, 1'b1);
        step();
        check("bp_out2", bus.alu_a,         32'd22);
        check("bp_rdy2", 32'(bus.in_ready), 32'd1);
        step();
        check("bp_out3", bus.alu_a,          32'd33);
        check("bp_v3",   32'(bus.out_valid), 32'd1);
        drive(1'b0, 0, 0, 0, 0, 1'b1);
        step();
        check("bp_empty", 32'(bus.out_valid), 32'd0);

        // Reset with both slots full.
        drive(1'b1, ADD_X2, 32'h200, 32'd44, 32'd1, 1'b0);
        step();
        drive(1'b1, 32'h0020_8463, 32'h204, 32'd55, 32'd2, 1'b0);
        step();
        check("full_ready", 32'(bus.in_ready), 32'd0);
        n_rst = 1'b0;
        drive(1'b0, 0, 0, 0, 0, 1'b0);
        step();
        check("rs_valid", 32'(bus.out_valid), 32'd0);
        check("rs_a",     bus.alu_a,          32'd0);
        check("rs_b",     bus.alu_b,          32'd0);
        check("rs_op",    32'(bus.alu_op),    32'd0);
        check("rs_rd",    32'(bus.rd),        32'd0);
        check("rs_we",    32'(bus.rd_we),     32'd0);
        check("rs_br",    32'(bus.is_branch), 32'd0);
        check("rs_f3",    32'(bus.br_funct3), 32'd0);
        check("rs_ill",   32'(bus.illegal),   32'd0);
        check("rs_ready", 32'(bus.in_ready),  32'd0);
        n_rst = 1'b1;
        step();
        check("rs_rel_ready", 32'(bus.in_ready), 32'd1);

        for (int i = 0; i < 2000; i++) begin
            n_rst = ($urandom_range(0, 99) != 0);
            drive(($urandom_range(0, 3) != 0), rand_instr(), $urandom, rand_data(), rand_data(),
                  ($urandom_range(0, 2) != 0));
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
